inst_prefetch: RTL and testbench
================================

INST_PREFETCH -- requirements
Module: inst_prefetch

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning instruction-queue entries (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port im_req_valid  output  1  fetch request to instruction memory.
REQ-006 SHALL have port im_req_ready  input  1  memory accepts request this cycle.
REQ-007 SHALL have port im_req_addr  output  32  fetch address.
REQ-008 SHALL have port im_rsp_valid  input  1  instruction returned; responses in request order, latency >= 1 cycle.
REQ-009 SHALL have port im_rsp_data  input  32  returned instruction word.
REQ-010 SHALL have port PC_R  input  1  redirect from execute (taken branch/jump).
REQ-011 SHALL have port PC_DISP  input  32  redirect target.
REQ-012 SHALL have port STALL_DE  input  1  decode cannot accept an instruction this cycle.
REQ-013 SHALL have port InstrD  output  32  instruction to decode.
REQ-014 SHALL have port PC_DE  output  32  address of InstrD.
REQ-015 SHALL have port instr_valid  output  1  InstrD/PC_DE valid.

Function
REQ-016 SHALL keep FIFO of {pc, instr} pairs, DEPTH entries, head drives InstrD/PC_DE.
REQ-017 SHALL drive instr_valid=1 iff FIFO non-empty (or bypass per REQ-031); otherwise InstrD=32'h0000_0013 (NOP), PC_DE=0.
REQ-018 SHALL pop head when instr_valid && !STALL_DE && !PC_R.
REQ-019 SHALL issue im_req_valid only in state RUN and only when occupancy + outstanding < DEPTH (credit rule; FIFO never overflows).
REQ-020 SHALL advance fetch PC by 4 (mod 2^32, wrap 32'hFFFF_FFFC -> 0) on each im_req_valid && im_req_ready.
REQ-021 SHALL hold im_req_addr stable while im_req_valid && !im_req_ready, unless PC_R.
REQ-022 SHALL track outstanding (0..DEPTH): +1 on accepted request, -1 on im_rsp_valid, both same cycle = unchanged.
REQ-023 SHALL, in RUN, push each response with the pc of its request (pc queue or pc = head pc + 4*position).
REQ-024 SHALL implement FSM states RUN and DRAIN.
REQ-025 SHALL, on PC_R (any state, highest priority): clear FIFO, set fetch PC := PC_DISP, suppress im_req_valid that cycle, discard any same-cycle response, no pop.
REQ-026 SHALL after PC_R go to DRAIN if outstanding after this cycle > 0, else RUN.
REQ-027 SHALL in DRAIN hold im_req_valid=0, drop all responses, move to RUN the cycle after outstanding reaches 0.
REQ-028 SHALL on PC_R during DRAIN update fetch PC to new PC_DISP, remain DRAIN.
REQ-029 SHALL accept push and pop in the same cycle when full (credit rule guarantees no loss).

Reset
REQ-030 SHALL on rst asynchronously: FIFO empty, outstanding=0, state RUN, fetch PC=RESET_PC, im_req_valid=0, instr_valid=0, InstrD=NOP, PC_DE=0; requests resume first cycle after deassertion; reset mid-transaction discards in-flight responses (memory reset with block).

Configuration
REQ-031 SHALL support macro INST_PREFETCH_BYPASS_EN: when defined, a response arriving in RUN with FIFO empty, !STALL_DE, !PC_R is presented combinationally that cycle (instr_valid=1) and consumed without FIFO write; when undefined, every response is written to FIFO and visible no earlier than next cycle.

Verification
REQ-032 SHALL cover: reset, im_req_ready=1, 1-cycle memory -> addresses 0,4,8,12 issued back to back; first instr_valid cycle 2 (non-bypass) with PC_DE=0.
REQ-033 SHALL cover: STALL_DE held 10 cycles, DEPTH=4 -> at most 4 requests outstanding+stored, no FIFO overflow, order preserved on release.
REQ-034 SHALL cover: PC_R=1, PC_DISP=32'h100 with 2 outstanding -> DRAIN, both responses dropped, next request address 32'h100, first PC_DE=32'h100.
REQ-035 SHALL cover: PC_R and im_rsp_valid same cycle with FIFO full -> FIFO empty next cycle, instr_valid=0, no pop of old head.
REQ-036 SHALL cover: RESET_PC=32'hFFFF_FFF8 -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-037 SHALL cover: with INST_PREFETCH_BYPASS_EN, empty FIFO, response 32'h0050_0093 -> InstrD=32'h0050_0093, instr_valid=1 same cycle.

Source files
------------

// File: rtl/inst_prefetch.sv
// inst_prefetch: instruction prefetch unit sitting between instruction memory and decode.
//
// Issues sequential fetch requests, buffers returned words in a DEPTH-entry queue of
// {pc, instr} pairs, and presents the head to decode. Credit-based issue (stored +
// in-flight < DEPTH) means the queue can never overflow. A redirect (PC_R) flushes the
// queue and retargets fetch. Requests still in flight from before the redirect are
// drained and dropped in StDrain.
//
// Parameters:
//   DEPTH    - queue entries (power of two, 2..16)
//   RESET_PC - first fetch address after reset
//
// Ports:
//   clk, rst                     - clock, asynchronous active-high reset
//   im_req_valid/ready/addr      - fetch request channel to instruction memory
//   im_rsp_valid/data            - in-order responses from instruction memory
//   PC_R, PC_DISP                - redirect strobe and target from execute
//   STALL_DE                     - decode cannot accept this cycle
//   InstrD, PC_DE, instr_valid   - instruction, its address and valid to decode
//
// Build option:
//   INST_PREFETCH_BYPASS_EN - when defined, a response arriving in StRun with the queue
//                             empty, decode ready and no redirect is passed straight
//                             through to decode in the same cycle without being stored.
module inst_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        im_req_valid,
  input  logic        im_req_ready,
  output logic [31:0] im_req_addr,
  input  logic        im_rsp_valid,
  input  logic [31:0] im_rsp_data,
  input  logic        PC_R,
  input  logic [31:0] PC_DISP,
  input  logic        STALL_DE,
  output logic [31:0] InstrD,
  output logic [31:0] PC_DE,
  output logic        instr_valid
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [31:0] Nop = 32'h0000_0013;

  typedef enum logic [0:0] {StRun, StDrain} state_e;

  state_e         state_q, state_d;
  logic [31:0]    fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]  outstanding_q, outstanding_d;
  logic [CW-1:0]  count_q, count_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [31:0]    pc_mem    [DEPTH];
  logic [31:0]    instr_mem [DEPTH];

  logic [CW:0]    inflight;
  logic           credit_ok;
  logic           req_fire;
  logic           rsp_take;
  logic           fifo_valid;
  logic           bypass;
  logic           push;
  logic           pop;
  logic [31:0]    rsp_pc;

  assign inflight   = (CW+1)'(count_q) + (CW+1)'(outstanding_q);
  assign credit_ok  = inflight < (CW+1)'(DEPTH);
  assign fifo_valid = (count_q != '0);

  // Gated by rst so no request is visible while reset is held.
  assign im_req_valid = !rst && (state_q == StRun) && !PC_R && credit_ok;
  assign im_req_addr  = fetch_pc_q;
  assign req_fire     = im_req_valid && im_req_ready;
  assign rsp_take     = im_rsp_valid && (outstanding_q != '0);

  // In StRun every in-flight request is sequential and ends at fetch_pc_q - 4, so the
  // oldest one (the one responding now) sits outstanding_q words behind fetch_pc_q.
  assign rsp_pc = fetch_pc_q - (32'(outstanding_q) << 2);

`ifdef INST_PREFETCH_BYPASS_EN
  assign bypass = (state_q == StRun) && !fifo_valid && im_rsp_valid && !STALL_DE && !PC_R;
`else
  assign bypass = 1'b0;
`endif

  assign instr_valid = fifo_valid || bypass;
  assign pop         = fifo_valid && !STALL_DE && !PC_R;
  assign push        = (state_q == StRun) && im_rsp_valid && !PC_R && !bypass;

  always_comb begin : next_state
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;

    // Responses still decrement even when dropped (redirect or drain).
    if (req_fire && !rsp_take) begin
      outstanding_d = outstanding_q + CW'(1);
    end else if (!req_fire && rsp_take) begin
      outstanding_d = outstanding_q - CW'(1);
    end

    if (PC_R) begin
      fetch_pc_d = PC_DISP;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      state_d    = (outstanding_d != '0) ? StDrain : StRun;
    end else begin
      case (state_q)
        StRun: begin
          if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
          if (push) wr_ptr_d = wr_ptr_q + AW'(1);
          if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
          if (push && !pop) begin
            count_d = count_q + CW'(1);
          end else if (pop && !push) begin
            count_d = count_q - CW'(1);
          end
        end
        StDrain: begin
          if (outstanding_d == '0) state_d = StRun;
        end
        default: state_d = StRun;
      endcase
    end
  end

  always_comb begin : decode_out
    InstrD = Nop;
    PC_DE  = '0;
    if (fifo_valid) begin
      InstrD = instr_mem[rd_ptr_q];
      PC_DE  = pc_mem[rd_ptr_q];
    end else if (bypass) begin
      InstrD = im_rsp_data;
      PC_DE  = rsp_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StRun;
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only read when count_q says they are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= rsp_pc;
      instr_mem[wr_ptr_q] <= im_rsp_data;
    end
  end

endmodule

// File: tb/tb_inst_prefetch.sv
module tb_inst_prefetch;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } pend_t;

`ifdef INST_PREFETCH_BYPASS_EN
  localparam int FirstValid = 1;
`else
  localparam int FirstValid = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        im_req_valid;
  logic        im_req_ready = 1'b0;
  logic [31:0] im_req_addr;
  logic        im_rsp_valid = 1'b0;
  logic [31:0] im_rsp_data = '0;
  logic        PC_R = 1'b0;
  logic [31:0] PC_DISP = '0;
  logic        STALL_DE = 1'b0;
  logic [31:0] InstrD;
  logic [31:0] PC_DE;
  logic        instr_valid;

  // Second instance: wrap-around of the fetch PC from a high reset address.
  logic        w_req_valid;
  logic [31:0] w_req_addr;
  logic        w_rsp_valid = 1'b0;
  logic [31:0] w_rsp_data = '0;
  logic        w_pc_r = 1'b0;
  logic [31:0] w_pc_disp = '0;
  logic        w_stall = 1'b0;
  logic [31:0] w_instr;
  logic [31:0] w_pc_de;
  logic        w_instr_valid;

  int          checks = 0;
  int          passed = 0;
  int unsigned cyc = 0;
  int unsigned lat = 1;
  int unsigned budget = 0;
  int unsigned acc_cnt = 0;
  logic [31:0] acc_log[$];
  pend_t       pend[$];
  logic [31:0] exp_pc[$];
  logic        hold_vld = 1'b0;
  logic [31:0] hold_addr = '0;

  logic        w_pend_vld = 1'b0;
  logic [31:0] w_pend_addr = '0;
  logic [31:0] w_log[$];
  logic [31:0] w_pc_log[$];
  logic [31:0] w_first_instr = '0;

  inst_prefetch #(.DEPTH(4), .RESET_PC(32'h0000_0000)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .im_req_valid (im_req_valid),
    .im_req_ready (im_req_ready),
    .im_req_addr  (im_req_addr),
    .im_rsp_valid (im_rsp_valid),
    .im_rsp_data  (im_rsp_data),
    .PC_R         (PC_R),
    .PC_DISP      (PC_DISP),
    .STALL_DE     (STALL_DE),
    .InstrD       (InstrD),
    .PC_DE        (PC_DE),
    .instr_valid  (instr_valid)
  );

  inst_prefetch #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk          (clk),
    .rst          (rst),
    .im_req_valid (w_req_valid),
    .im_req_ready (1'b1),
    .im_req_addr  (w_req_addr),
    .im_rsp_valid (w_rsp_valid),
    .im_rsp_data  (w_rsp_data),
    .PC_R         (w_pc_r),
    .PC_DISP      (w_pc_disp),
    .STALL_DE     (w_stall),
    .InstrD       (w_instr),
    .PC_DE        (w_pc_de),
    .instr_valid  (w_instr_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0) ? 32'h0050_0093 : ~a;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Memory model + monitor for the main instance. Drives responses at +2 after the edge,
  // samples the settled cycle at +3.
  always @(posedge clk) begin
    #2;
    cyc++;
    if (rst) begin
      pend.delete();
      acc_log.delete();
      acc_cnt      = 0;
      im_rsp_valid = 1'b0;
      im_rsp_data  = '0;
      im_req_ready = 1'b0;
      hold_vld     = 1'b0;
    end else begin
      im_rsp_valid = 1'b0;
      im_rsp_data  = '0;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        im_rsp_valid = 1'b1;
        im_rsp_data  = mem_word(pend[0].addr);
        void'(pend.pop_front());
      end
      im_req_ready = (acc_cnt < budget);
      #1;
      if (im_req_valid && hold_vld) check("addr_hold", im_req_addr, hold_addr);
      hold_vld  = im_req_valid && !im_req_ready;
      hold_addr = im_req_addr;
      if (im_req_valid && im_req_ready) begin
        pend.push_back('{addr: im_req_addr, due: cyc + lat});
        acc_log.push_back(im_req_addr);
        acc_cnt++;
      end
      if (instr_valid && !STALL_DE && !PC_R) begin
        if (exp_pc.size() == 0) begin
          checks++;
          $display("FAIL unexpected_instr: got pc %h instr %h expected none", PC_DE, InstrD);
        end else begin
          logic [31:0] e;
          e = exp_pc.pop_front();
          check("decode_pc", PC_DE, e);
          check("decode_instr", InstrD, mem_word(e));
        end
      end
    end
  end

  // Fixed 1-cycle, always-ready memory for the wrap instance.
  always @(posedge clk) begin
    #2;
    if (rst) begin
      w_rsp_valid = 1'b0;
      w_pend_vld  = 1'b0;
    end else begin
      w_rsp_valid = w_pend_vld;
      w_rsp_data  = mem_word(w_pend_addr);
      #1;
      w_pend_vld  = w_req_valid;
      w_pend_addr = w_req_addr;
      if (w_req_valid && w_log.size() < 3) w_log.push_back(w_req_addr);
      if (w_instr_valid && w_pc_log.size() < 3) begin
        if (w_pc_log.size() == 0) w_first_instr = w_instr;
        w_pc_log.push_back(w_pc_de);
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst      = 1'b1;
    PC_R     = 1'b0;
    STALL_DE = 1'b0;
    budget   = 0;
    exp_pc.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic release_rst();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_acc(input int unsigned n, input string name);
    int k;
    k = 0;
    while (acc_cnt < n && k < 50) begin
      @(negedge clk);
      k++;
    end
    check(name, acc_cnt, n);
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while (exp_pc.size() != 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(exp_pc.size()), 32'd0);
    repeat (6) @(negedge clk);
  endtask

  initial begin
    int          first;
    logic [31:0] first_pc;
    logic [31:0] first_instr;

    // Reset state (rst asserted from time 0).
    @(negedge clk);
    check("rst_req_valid", 32'(im_req_valid), 32'd0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instrd_nop", InstrD, 32'h0000_0013);
    check("rst_pc_de", PC_DE, 32'h0);
    check("rst_wrap_req_valid", 32'(w_req_valid), 32'd0);

    // Back-to-back fetch with 1-cycle memory.
    lat    = 1;
    budget = 6;
    for (int i = 0; i < 6; i++) exp_pc.push_back(32'(4 * i));
    release_rst();
    first       = -1;
    first_pc    = '1;
    first_instr = '1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i < 4) begin
        check("b2b_req_valid", 32'(im_req_valid && im_req_ready), 32'd1);
        check("b2b_req_addr", im_req_addr, 32'(4 * i));
      end
      if (first < 0 && instr_valid) begin
        first       = i;
        first_pc    = PC_DE;
        first_instr = InstrD;
      end
    end
    check("first_valid_cycle", 32'(first), 32'(FirstValid));
    check("first_pc_de", first_pc, 32'h0);
    check("first_instr", first_instr, 32'h0050_0093);
    wait_drain("b2b_drain");
    check("b2b_accepted", acc_cnt, 6);

    // Decode stalled for 10 cycles: credit caps stored + in-flight at DEPTH.
    do_reset();
    lat      = 1;
    budget   = 8;
    STALL_DE = 1'b1;
    for (int i = 0; i < 8; i++) exp_pc.push_back(32'(4 * i));
    release_rst();
    repeat (10) @(negedge clk);
    check("stall_accepted", acc_cnt, 4);
    check("stall_head_valid", 32'(instr_valid), 32'd1);
    check("stall_head_pc", PC_DE, 32'h0);
    @(posedge clk); #1;
    STALL_DE = 1'b0;
    wait_drain("stall_drain");
    check("stall_total", acc_cnt, 8);

    // Redirect with 2 requests in flight -> drain, then fetch from 0x100.
    do_reset();
    lat      = 3;
    budget   = 2;
    STALL_DE = 1'b1;
    release_rst();
    wait_acc(2, "redir_two_inflight");
    @(posedge clk); #1;
    PC_R    = 1'b1;
    PC_DISP = 32'h0000_0100;
    @(negedge clk);
    check("redir_req_suppressed", 32'(im_req_valid), 32'd0);
    @(posedge clk); #1;
    PC_R     = 1'b0;
    STALL_DE = 1'b0;
    budget   = 5;
    exp_pc.push_back(32'h100);
    exp_pc.push_back(32'h104);
    exp_pc.push_back(32'h108);
    @(negedge clk);
    check("drain_req_valid", 32'(im_req_valid), 32'd0);
    check("drain_instr_valid", 32'(instr_valid), 32'd0);
    wait_drain("redir_drain");
    check("redir_log_size", 32'(acc_log.size()), 32'd5);
    if (acc_log.size() == 5) begin
      check("redir_addr0", acc_log[2], 32'h100);
      check("redir_addr1", acc_log[3], 32'h104);
      check("redir_addr2", acc_log[4], 32'h108);
    end

    // Redirect in the same cycle as a response arriving into a nearly full queue.
    do_reset();
    lat      = 2;
    budget   = 4;
    STALL_DE = 1'b1;
    release_rst();
    wait_acc(4, "flush_four_issued");
    @(posedge clk); #1;
    @(posedge clk); #1;
    PC_R     = 1'b1;
    PC_DISP  = 32'h0000_0200;
    STALL_DE = 1'b0;
    @(negedge clk);
    check("flush_old_head_valid", 32'(instr_valid), 32'd1);
    check("flush_old_head_pc", PC_DE, 32'h0);
    @(posedge clk); #1;
    PC_R   = 1'b0;
    budget = 6;
    exp_pc.push_back(32'h200);
    exp_pc.push_back(32'h204);
    @(negedge clk);
    check("flush_instr_valid", 32'(instr_valid), 32'd0);
    check("flush_instrd_nop", InstrD, 32'h0000_0013);
    check("flush_pc_de", PC_DE, 32'h0);
    wait_drain("flush_drain");

    // Wrap instance: first three fetches and decoded pcs after the very first reset.
    check("wrap_log_size", 32'(w_log.size()), 32'd3);
    if (w_log.size() == 3) begin
      check("wrap_addr0", w_log[0], 32'hFFFF_FFF8);
      check("wrap_addr1", w_log[1], 32'hFFFF_FFFC);
      check("wrap_addr2", w_log[2], 32'h0000_0000);
    end
    check("wrap_pc_log_size", 32'(w_pc_log.size()), 32'd3);
    if (w_pc_log.size() == 3) begin
      check("wrap_pc0", w_pc_log[0], 32'hFFFF_FFF8);
      check("wrap_pc1", w_pc_log[1], 32'hFFFF_FFFC);
      check("wrap_pc2", w_pc_log[2], 32'h0000_0000);
    end
    check("wrap_instr0", w_first_instr, 32'h0000_0007);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
